// File: rtl/clk_div_gen_pkg.sv
// clk_div_gen_pkg: shared types and helpers for the divided-clock generator.
// Holds the lock FSM encoding and the duty-cycle helper.
package clk_div_gen_pkg;

    localparam int unsigned DIV_MIN = 2;

    typedef enum logic [1:0] {
        ST_ALIGN,
        ST_LOCKING,
        ST_LOCKED
    } state_t;

    // High time of a channel; odd ratios keep the extra cycle high.
    function automatic int unsigned hi_of(input int unsigned div);
        return (div + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divided-clock channel with phase preload.
// Produces a registered clock and a strobe on its rising edge.
module clk_div_chan
    import clk_div_gen_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] phase,
    input  logic             load,
    input  logic             run,
    output logic             outclk,
    output logic             outclk_en
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] hi;
    logic [DIV_W-1:0] last;

    assign hi   = DIV_W'(hi_of(32'(div)));
    assign last = div - DIV_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            outclk    <= 1'b0;
            outclk_en <= 1'b0;
        end else if (load) begin
            cnt       <= phase;
            outclk    <= 1'b0;
            outclk_en <= 1'b0;
        end else if (run) begin
            cnt       <= (cnt == last) ? '0 : cnt + DIV_W'(1);
            outclk    <= (cnt < hi);
            outclk_en <= (cnt == '0);
        end
    end

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: NUM_CLKS programmable divided clocks from refclk.
// Shadow/active config, write validation and the lock FSM.
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int NUM_CLKS    = 4,
    parameter int DIV_W       = 8,
    parameter int DEF_DIV     = 2,
    parameter int LOCK_CYCLES = 16,
    parameter int SEL_W       = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                cfg_wr,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [DIV_W-1:0]    cfg_phase,
    input  logic                cfg_apply,
    output logic                cfg_err,
    output logic [NUM_CLKS-1:0] outclk,
    output logic [NUM_CLKS-1:0] outclk_en,
    output logic                locked
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEF_DIV);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    logic [DIV_W-1:0] sh_div    [NUM_CLKS];
    logic [DIV_W-1:0] sh_phase  [NUM_CLKS];
    logic [DIV_W-1:0] act_div   [NUM_CLKS];
    logic [DIV_W-1:0] act_phase [NUM_CLKS];

    state_t         state;
    logic [LCW-1:0] lock_cnt;
    logic           sel_ok;
    logic           wr_ok;
    logic           load;
    logic           run;

    assign sel_ok = {1'b0, cfg_sel} < (SEL_W + 1)'(NUM_CLKS);
    assign wr_ok  = sel_ok
                 && (cfg_div >= DIV_W'(DIV_MIN))
                 && (cfg_phase < cfg_div);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLKS; i++) begin
                sh_div[i]   <= DIV_RST;
                sh_phase[i] <= '0;
            end
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !wr_ok;
            if (cfg_wr && wr_ok) begin
                sh_div[cfg_sel]   <= cfg_div;
                sh_phase[cfg_sel] <= cfg_phase;
            end
        end
    end

    // Apply samples shadow before any same-edge write lands.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLKS; i++) begin
                act_div[i]   <= DIV_RST;
                act_phase[i] <= '0;
            end
        end else if (cfg_apply) begin
            act_div   <= sh_div;
            act_phase <= sh_phase;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ALIGN;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (cfg_apply) begin
            state  <= ST_ALIGN;
            locked <= 1'b0;
        end else begin
            unique case (state)
                ST_ALIGN: begin
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                    state    <= ST_LOCKING;
                end
                ST_LOCKING: begin
                    lock_cnt <= lock_cnt + LCW'(1);
                    if (lock_cnt == LOCK_LAST) begin
                        state  <= ST_LOCKED;
                        locked <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    locked <= 1'b1;
                end
                default: begin
                    state  <= ST_ALIGN;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    assign load = (state == ST_ALIGN);
    assign run  = (state == ST_LOCKING) || (state == ST_LOCKED);

    for (genvar g = 0; g < NUM_CLKS; g++) begin : g_chan
        clk_div_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clk       (refclk),
            .rst_n     (rst_n),
            .div       (act_div[g]),
            .phase     (act_phase[g]),
            .load      (load),
            .run       (run),
            .outclk    (outclk[g]),
            .outclk_en (outclk_en[g])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: scoreboard plus table/pattern checks for clk_div_gen.
// Three channels so an out-of-range channel select is representable.
module tb_clk_div_gen;

    localparam int NUM_CLKS    = 3;
    localparam int DIV_W       = 8;
    localparam int DEF_DIV     = 2;
    localparam int LOCK_CYCLES = 16;
    localparam int SEL_W       = 2;

    logic                refclk = 1'b0;
    logic                rst_n  = 1'b1;
    logic                cfg_wr = 1'b0;
    logic [SEL_W-1:0]    cfg_sel = '0;
    logic [DIV_W-1:0]    cfg_div = '0;
    logic [DIV_W-1:0]    cfg_phase = '0;
    logic                cfg_apply = 1'b0;
    logic                cfg_err;
    logic [NUM_CLKS-1:0] outclk;
    logic [NUM_CLKS-1:0] outclk_en;
    logic                locked;

    clk_div_gen #(
        .NUM_CLKS    (NUM_CLKS),
        .DIV_W       (DIV_W),
        .DEF_DIV     (DEF_DIV),
        .LOCK_CYCLES (LOCK_CYCLES),
        .SEL_W       (SEL_W)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .cfg_wr    (cfg_wr),
        .cfg_sel   (cfg_sel),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_apply (cfg_apply),
        .cfg_err   (cfg_err),
        .outclk    (outclk),
        .outclk_en (outclk_en),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic [NUM_CLKS-1:0] clk;
        logic [NUM_CLKS-1:0] en;
        logic                lk;
        logic                err;
    } exp_t;

    typedef struct {
        int   sel;
        int   dv;
        int   ph;
        logic err;
    } cfg_vec_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   edge_n  = 0;
    int   align_e = 0;
    int   sh_div[NUM_CLKS];
    int   sh_ph[NUM_CLKS];
    int   ac_div[NUM_CLKS];
    int   ac_ph[NUM_CLKS];

    logic [NUM_CLKS-1:0] obs_clk [int];
    logic [NUM_CLKS-1:0] obs_en  [int];
    logic                obs_lk  [int];
    logic                obs_err [int];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Closed-form expectation: cycles since realign, modulo the ratio.
    function automatic exp_t model(input int e, input logic err);
        exp_t x;
        int   c;
        x = '0;
        for (int ch = 0; ch < NUM_CLKS; ch++) begin
            if (e > align_e) begin
                c = (ac_ph[ch] + e - align_e - 1) % ac_div[ch];
                x.clk[ch] = (c < (ac_div[ch] + 1) / 2);
                x.en[ch]  = (c == 0);
            end
        end
        x.lk  = (e >= align_e + LOCK_CYCLES);
        x.err = err;
        return x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CLKS; i++) begin
            sh_div[i] = DEF_DIV;
            sh_ph[i]  = 0;
            ac_div[i] = DEF_DIV;
            ac_ph[i]  = 0;
        end
    endtask

    task automatic cyc(input logic wr, input int sel, input int dv,
                       input int ph, input logic ap);
        exp_t x;
        exp_t got;
        logic ok;
        cfg_wr    = wr;
        cfg_sel   = SEL_W'(sel);
        cfg_div   = DIV_W'(dv);
        cfg_phase = DIV_W'(ph);
        cfg_apply = ap;
        ok = (sel < NUM_CLKS) && (dv >= 2) && (ph < dv);
        edge_n++;
        x = model(edge_n, wr && !ok);
        if (ap) x.lk = 1'b0;
        sb.push_back(x);
        if (ap) begin
            ac_div  = sh_div;
            ac_ph   = sh_ph;
            align_e = edge_n + 1;
        end
        if (wr && ok) begin
            sh_div[sel] = dv;
            sh_ph[sel]  = ph;
        end
        @(posedge refclk);
        #1;
        obs_clk[edge_n] = outclk;
        obs_en[edge_n]  = outclk_en;
        obs_lk[edge_n]  = locked;
        obs_err[edge_n] = cfg_err;
        got = {outclk, outclk_en, locked, cfg_err};
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            x = sb.pop_front();
            chk($sformatf("sb_edge%0d", edge_n), got, x);
        end
        cfg_wr    = 1'b0;
        cfg_apply = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {outclk, outclk_en, locked, cfg_err}, 0);
        @(posedge refclk);
        edge_n++;
        #1;
        chk("rst_hold", {outclk, outclk_en, locked, cfg_err}, 0);
        rst_n = 1'b1;
        model_reset();
        align_e = edge_n + 1;
        sb.delete();
    endtask

    task automatic check_pat(input string nm, input int ch, input int st,
                             input logic use_en, input logic [15:0] pat,
                             input int len);
        logic [15:0] got;
        got = '0;
        for (int i = 0; i < len; i++) begin
            if (use_en) got[len-1-i] = obs_en[st+i][ch];
            else        got[len-1-i] = obs_clk[st+i][ch];
        end
        chk(nm, got, pat);
    endtask

    cfg_vec_t vt[6];
    int       a;

    initial begin
        vt[0] = '{sel: 0, dv: 1, ph: 0, err: 1'b1};
        vt[1] = '{sel: 1, dv: 4, ph: 4, err: 1'b1};
        vt[2] = '{sel: 3, dv: 4, ph: 0, err: 1'b1};
        vt[3] = '{sel: 2, dv: 0, ph: 0, err: 1'b1};
        vt[4] = '{sel: 1, dv: 3, ph: 3, err: 1'b1};
        vt[5] = '{sel: 2, dv: 5, ph: 2, err: 1'b0};

        // Defaults after reset release
        do_reset();
        a = align_e;
        idle(20);
        check_pat("t1_ch0_clk", 0, a + 1, 1'b0, 16'b10101010, 8);
        check_pat("t1_ch2_clk", 2, a + 1, 1'b0, 16'b10101010, 8);
        check_pat("t1_ch0_en", 0, a + 1, 1'b1, 16'b10101010, 8);
        chk("t1_align_clk", obs_clk[a], 0);
        chk("t1_lock_pre", obs_lk[a + 15], 0);
        chk("t1_lock_at", obs_lk[a + 16], 1);

        // Odd ratios and a phase offset
        cyc(1'b1, 1, 3, 0, 1'b0);
        cyc(1'b1, 2, 5, 2, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1);
        a = align_e;
        idle(20);
        chk("t2_lock_drop", obs_lk[a - 1], 0);
        check_pat("t2_ch1_clk", 1, a + 1, 1'b0, 16'b110110, 6);
        check_pat("t2_ch2_clk", 2, a + 1, 1'b0, 16'b1001110011, 10);
        check_pat("t2_ch2_en", 2, a + 1, 1'b1, 16'b0001000010, 10);
        chk("t2_lock_pre", obs_lk[a + 15], 0);
        chk("t2_lock_at", obs_lk[a + 16], 1);

        // Rejected writes leave shadow intact
        foreach (vt[i]) begin
            cyc(1'b1, vt[i].sel, vt[i].dv, vt[i].ph, 1'b0);
            chk($sformatf("t3_err%0d", i), obs_err[edge_n], vt[i].err);
            idle(1);
            chk($sformatf("t3_pulse%0d", i), obs_err[edge_n], 0);
        end
        cyc(1'b0, 0, 0, 0, 1'b1);
        a = align_e;
        idle(12);
        check_pat("t3_ch0_clk", 0, a + 1, 1'b0, 16'b101010, 6);
        check_pat("t3_ch1_clk", 1, a + 1, 1'b0, 16'b110110, 6);
        check_pat("t3_ch2_clk", 2, a + 1, 1'b0, 16'b1001110011, 10);

        // Write coincident with apply lands in shadow only
        cyc(1'b1, 0, 4, 0, 1'b1);
        a = align_e;
        idle(8);
        check_pat("t4_ch0_old", 0, a + 1, 1'b0, 16'b101010, 6);
        cyc(1'b0, 0, 0, 0, 1'b1);
        a = align_e;
        idle(20);
        check_pat("t4_ch0_new", 0, a + 1, 1'b0, 16'b11001100, 8);

        // Apply while locked realigns every channel
        cyc(1'b1, 1, 4, 0, 1'b0);
        cyc(1'b1, 2, 4, 1, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1);
        idle(20);
        chk("t5_locked_before", obs_lk[edge_n], 1);
        cyc(1'b0, 0, 0, 0, 1'b1);
        a = align_e;
        idle(10);
        chk("t5_lock_drop", obs_lk[a - 1], 0);
        chk("t5_align_zero", obs_clk[a], 0);
        chk("t5_rise_all", obs_clk[a + 1], 3'b111);
        chk("t5_en_first", obs_en[a + 1], 3'b011);
        check_pat("t5_ch1_clk", 1, a + 1, 1'b0, 16'b11001100, 8);
        check_pat("t5_ch2_clk", 2, a + 1, 1'b0, 16'b10011001, 8);

        // Reset in the middle of a run
        idle(3);
        do_reset();
        a = align_e;
        idle(20);
        check_pat("t6_ch0_clk", 0, a + 1, 1'b0, 16'b10101010, 8);
        check_pat("t6_ch1_clk", 1, a + 1, 1'b0, 16'b10101010, 8);
        check_pat("t6_ch2_clk", 2, a + 1, 1'b0, 16'b10101010, 8);
        chk("t6_lock_pre", obs_lk[a + 15], 0);
        chk("t6_lock_at", obs_lk[a + 16], 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
Parametrised all-digital clock generator that follows on from the fixed two-output PLL wrapper. It derives NUM_CLKS divided clocks from a single reference clock. Each channel has a runtime-programmable divide ratio and phase offset, plus a one-cycle clock-enable strobe. A lock indicator asserts after a programmable settle time. All outputs are generated synchronously to refclk and feed SDRAM/camera-side logic that needs related slower clocks or enables.

Parameters:
NUM_CLKS, 4, number of output channels (1..16)
DIV_W, 8, width of divide/phase fields; max ratio 2**DIV_W-1
DEF_DIV, 2, reset divide ratio of every channel (2..2**DIV_W-1)
LOCK_CYCLES, 16, refclk cycles spent in LOCKING before locked asserts (>=1)
SEL_W, $clog2(NUM_CLKS) (min 1), channel-select width

Ports:
refclk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
cfg_wr  in  1  write shadow config of channel cfg_sel
cfg_sel  in  SEL_W  target channel
cfg_div  in  DIV_W  divide ratio N
cfg_phase  in  DIV_W  phase offset in refclk cycles
cfg_apply  in  1  copy all shadow regs to active regs and realign
cfg_err  out  1  one-cycle pulse: rejected write
outclk  out  NUM_CLKS  divided clocks (registered)
outclk_en  out  NUM_CLKS  one-cycle strobe coincident with each outclk rising edge
locked  out  1  outputs stable and phase-aligned

Behaviour:
- Reset (rst_n low, async): shadow and active div = DEF_DIV, phase = 0, counters = 0; outclk, outclk_en, cfg_err, locked = 0; FSM = ALIGN.
- Config write: accepted when cfg_wr=1, cfg_sel<NUM_CLKS, cfg_div>=2 and cfg_phase<cfg_div. Updates shadow only. Any other cfg_wr is ignored with no register change, and cfg_err=1 the next cycle.
- cfg_apply: active <= shadow values held before this edge. A cfg_wr in the same cycle lands in shadow only and takes effect on the next apply. The FSM goes to ALIGN from any state, and locked drops the next cycle.
- FSM states: ALIGN -> LOCKING -> LOCKED.
  - ALIGN (1 cycle): cnt_i <= phase_i; outclk, outclk_en <= 0; lock counter <= 0. Next state: LOCKING.
  - LOCKING: counters run; lock counter increments. Move to LOCKED when the lock counter reaches LOCK_CYCLES-1.
  - LOCKED: locked=1; counters run. Only cfg_apply or reset leaves this state.
- Counter per channel: cnt_i <= (cnt_i == div_i-1) ? 0 : cnt_i+1 in LOCKING/LOCKED.
- outclk_i <= (cnt_i < HI_i), with HI_i = (div_i+1)>>1. Odd N is high for (N+1)/2 cycles.
- outclk_en_i <= (cnt_i == 0). It is aligned with the outclk_i rising edge, one cycle wide, period N.
- Latency: ALIGN occurs in cycle A. cnt=phase in A+1; outclk reflects it in A+2. locked=1 from cycle A+1+LOCK_CYCLES.
- Phase: a channel with phase p leads a phase-0 channel of equal N by p cycles. Equal-N channels with equal phase are edge-identical.
- Reset mid-operation: immediate return to reset values. After rst_n rises, the first edge executes ALIGN with DEF_DIV and phase 0.
- Widths: all counter/compare logic is DIV_W bits. The lock counter is $clog2(LOCK_CYCLES+1) bits and saturates in LOCKED.

Decomposition:
- Package clk_div_gen_pkg: FSM state enum (ST_ALIGN, ST_LOCKING, ST_LOCKED), a function computing HI from div, and a DIV_MIN=2 constant.
- One sub-module, clk_div_chan: counter, HI compare, outclk/outclk_en registers, with inputs div, phase, load, run. Instantiated NUM_CLKS times by a generate loop.
- The top holds the shadow/active regs, config validation and the FSM.

Test Plan:
1. Reset release with defaults (DEF_DIV=2): from cycle A+2 every outclk = 1,0,1,0…; outclk_en = 1,0,1,0…; locked rises exactly at A+17.
2. Write ch1 div=3, ch2 div=5 phase=2, then apply. ch1 outclk = 1,1,0 repeating; ch2 outclk = 1,0,0,1,1 from A+2 (cnt starts at 2, HI=3); locked low for 16 cycles, then high.
3. Invalid writes: div=1, phase=4 with div=4, cfg_sel=NUM_CLKS (when NUM_CLKS is not a power of 2). Each gives a cfg_err 1-cycle pulse and leaves shadow unchanged, checked by a subsequent apply producing the old waveform.
4. cfg_wr ch0 div=4 in the same cycle as cfg_apply: outputs keep the old ratio after realign. A second apply switches ch0 to the 1,1,0,0 pattern.
5. Apply while LOCKED: locked=0 the next cycle; all channels restart phase-aligned (equal-N, phase-0 channels rise together at A+2).
6. Assert rst_n mid-run for 1 cycle: outputs and locked go 0 asynchronously; the config returns to DEF_DIV; lock timing restarts as in test 1.
